lookreg_checker: RTL

- Self-checking result monitor at the output end of the registered 32-bit lookahead adder (lookreg).
- Samples each operand set {a, b, cin} driven into the adder and computes the golden {cout, sum}.
- Delays the golden result to match the adder's register latency, compares it against the adder's sum/cout, and keeps pass/fail statistics.
- Used in regression benches and as an on-chip BIST monitor.

---
 rtl/lookreg_checker.sv | 119 +++++++++++
 1 files changed

// File: rtl/lookreg_checker.sv
// lookreg_checker: golden-result monitor for the registered lookahead adder.
// Delays a+b+cin by LATENCY cycles, compares with the adder output and keeps statistics.
//
//   state | meaning
//   IDLE  | no comparison made since reset or clear
//   RUN   | comparing results as they leave the delay line
//   HALT  | stopped on a mismatch (STOP_ON_ERR=1); waits for clear
module lookreg_checker #(
  parameter int WIDTH       = 32,
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  input  logic             clear,
  output logic             chk_valid,
  output logic             mismatch,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH:0]   first_err_exp,
  output logic [WIDTH:0]   first_err_got,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             st;
  logic [WIDTH:0]     exp_now;
  logic [WIDTH:0]     line_exp;
  logic [WIDTH:0]     got;
  logic [WIDTH:0]     dl_exp [LATENCY];
  logic [LATENCY-1:0] dl_vld;
  logic               line_vld;
  logic               do_cmp;
  logic               bad;
  logic               halt_now;

  assign exp_now  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign line_exp = dl_exp[LATENCY-1];
  assign line_vld = dl_vld[LATENCY-1];
  assign got      = {dut_cout, dut_sum};
  assign do_cmp   = line_vld && (st != HALT);
  assign bad      = (got != line_exp);
  assign halt_now = do_cmp && bad && (STOP_ON_ERR != 0);
  assign state    = st;

  // The data path shifts unconditionally; only the valid bits are affected by clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LATENCY; i++) dl_exp[i] <= '0;
      dl_vld <= '0;
    end else begin
      dl_exp[0] <= exp_now;
      dl_vld[0] <= in_valid && !clear;
      for (int i = 1; i < LATENCY; i++) begin
        dl_exp[i] <= dl_exp[i-1];
        dl_vld[i] <= dl_vld[i-1] && !clear;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st            <= IDLE;
      chk_valid     <= 1'b0;
      mismatch      <= 1'b0;
      err_sticky    <= 1'b0;
      pass_count    <= '0;
      err_count     <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (clear) begin
      st            <= IDLE;
      chk_valid     <= 1'b0;
      mismatch      <= 1'b0;
      err_sticky    <= 1'b0;
      pass_count    <= '0;
      err_count     <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else begin
      chk_valid <= do_cmp;
      mismatch  <= do_cmp && bad;
      if (do_cmp) begin
        if (bad) begin
          if (err_count != CNT_MAX) err_count <= err_count + 1'b1;
          if (!err_sticky) begin
            err_sticky    <= 1'b1;
            first_err_exp <= line_exp;
            first_err_got <= got;
          end
        end else if (pass_count != CNT_MAX) begin
          pass_count <= pass_count + 1'b1;
        end
      end
      case (st)
        IDLE:    if (do_cmp) st <= halt_now ? HALT : RUN;
        RUN:     if (halt_now) st <= HALT;
        HALT:    st <= HALT;
        default: st <= IDLE;
      endcase
    end
  end

endmodule
